// File: rtl/alu_bank_if.sv
// Instruction handshake and accumulator readback bundle for alu_bank.
interface alu_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ACCSEL = 2
);
    logic [4+ACCSEL+WIDTH-1:0] inst;
    logic                      inst_valid;
    logic                      inst_ready;
    logic [ACCSEL-1:0]         rd_sel;
    logic [WIDTH-1:0]          result;
    logic                      carry;
    logic                      zero;
    logic                      error;

    // Instruction sequencer / datapath consumer side
    modport master (
        output inst, inst_valid, rd_sel,
        input  inst_ready, result, carry, zero, error
    );

    // ALU bank side
    modport slave (
        input  inst, inst_valid, rd_sel,
        output inst_ready, result, carry, zero, error
    );
endinterface

// File: rtl/alu_bank.sv
// Bank of 2**ACCSEL accumulators with carry/zero flags, executing immediate
// instructions under valid/ready; MUL is a WIDTH-cycle shift-add sequence.
module alu_bank #(
    parameter int WIDTH  = 8,
    parameter int ACCSEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_bank_if.slave  bus
);
    localparam int NACC = 1 << ACCSEL;
    localparam int SHW  = $clog2(WIDTH);
    localparam int CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4, OP_AND = 4'h5, OP_IOR = 4'h6, OP_XOR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_MUL = 4'hA, OP_ADC = 4'hB;
    localparam logic [3:0] OP_MOV = 4'hC;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   acc_q [NACC];
    logic [WIDTH-1:0]   acc_d [NACC];
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ACCSEL-1:0]  sel_q, sel_d;

    logic [3:0]         code;
    logic [ACCSEL-1:0]  sel;
    logic [WIDTH-1:0]   imm;
    logic [WIDTH-1:0]   a;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_c;
    logic               alu_wr;
    logic               alu_cwr;
    logic               is_mul;
    logic               illegal;
    logic [2*WIDTH-1:0] prod_nx;

    assign {code, sel, imm} = bus.inst;
    assign a = acc_q[sel];

    // Single-cycle operation result, flag effects and opcode class
    always_comb begin
        sum     = '0;
        alu_val = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_cwr = 1'b0;
        is_mul  = 1'b0;
        illegal = 1'b0;
        case (code)
            OP_NOP: alu_wr = 1'b0;
            OP_LDI: alu_val = imm;
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, imm};
                alu_val = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_cwr = 1'b1;
            end
            OP_SUB: begin
                sum = {1'b0, a} - {1'b0, imm};
                alu_val = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_cwr = 1'b1;
            end
            OP_NOT: alu_val = ~a;
            OP_AND: alu_val = a & imm;
            OP_IOR: alu_val = a | imm;
            OP_XOR: alu_val = a ^ imm;
            OP_SHL: alu_val = a << imm[SHW-1:0];
            OP_SHR: alu_val = a >> imm[SHW-1:0];
            OP_MUL: begin
                alu_wr = 1'b0;
                is_mul = 1'b1;
            end
            OP_ADC: begin
                sum = {1'b0, a} + {1'b0, imm} + {{WIDTH{1'b0}}, carry_q};
                alu_val = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_cwr = 1'b1;
            end
            OP_MOV: alu_val = acc_q[imm[ACCSEL-1:0]];
            default: begin
                alu_wr = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

    assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Controller: accept, multiply sequencing and error lockout
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        case (state_q)
            ST_RESET: state_d = ST_READY;
            ST_READY: begin
                if (bus.inst_valid) begin
                    if (illegal) begin
                        state_d = ST_ERROR;
                        acc_d   = '{default: '0};
                        carry_d = 1'b0;
                        zero_d  = 1'b0;
                    end else if (is_mul) begin
                        state_d  = ST_BUSY;
                        prod_d   = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = imm;
                        cnt_d    = '0;
                        sel_d    = sel;
                    end else if (alu_wr) begin
                        acc_d[sel] = alu_val;
                        zero_d     = (alu_val == '0);
                        if (alu_cwr) carry_d = alu_c;
                    end
                end
            end
            ST_BUSY: begin
                prod_d   = prod_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // The final step commits the product as it is formed, so the
                // write lands WIDTH edges after accept rather than one later.
                if (cnt_q == LAST) begin
                    acc_d[sel_q] = prod_nx[WIDTH-1:0];
                    carry_d      = |prod_nx[2*WIDTH-1:WIDTH];
                    zero_d       = (prod_nx[WIDTH-1:0] == '0);
                    state_d      = ST_READY;
                end
            end
            default: begin
                state_d = ST_ERROR;
                acc_d   = '{default: '0};
                carry_d = 1'b0;
                zero_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESET;
            acc_q    <= '{default: '0};
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.inst_ready = (state_q == ST_READY);
    assign bus.error      = (state_q == ST_ERROR);
    assign bus.result     = acc_q[bus.rd_sel];
    assign bus.carry      = carry_q;
    assign bus.zero       = zero_q;
endmodule

// File: tb/tb_alu_bank.sv
// Directed table-driven bench for alu_bank (WIDTH=8, ACCSEL=2).
module tb_alu_bank;
    localparam int W = 8;
    localparam int A = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    alu_bank_if #(.WIDTH(W), .ACCSEL(A)) bus ();

    alu_bank #(.WIDTH(W), .ACCSEL(A)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   code;
        logic [A-1:0] sel;
        logic [W-1:0] imm;
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for ready at negedges, with inst already driven.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.inst_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.inst_ready) begin
            nvec++;
            nerr++;
            $display("FAIL %s: got ready=0 after %0d cycles, expected ready=1", name, n);
        end
    endtask

    // Presents one instruction, transfers it, returns at the negedge after accept.
    task automatic send(input logic [3:0] c, input logic [A-1:0] s, input logic [W-1:0] i);
        bus.inst       = {c, s, i};
        bus.inst_valid = 1'b1;
        wait_ready("send_ready");
        @(posedge clk);
        @(negedge clk);
        bus.inst_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{4'h1, 2'd1, 8'h05, 8'h05, 1'b0, 1'b0};
        tbl[1]  = '{4'h2, 2'd1, 8'hFC, 8'h01, 1'b1, 1'b0};
        tbl[2]  = '{4'hB, 2'd1, 8'h00, 8'h02, 1'b0, 1'b0};
        tbl[3]  = '{4'h1, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0};
        tbl[4]  = '{4'h3, 2'd0, 8'h04, 8'hFF, 1'b1, 1'b0};
        tbl[5]  = '{4'h3, 2'd0, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{4'h0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{4'h1, 2'd3, 8'h81, 8'h81, 1'b0, 1'b0};
        tbl[8]  = '{4'h8, 2'd3, 8'h09, 8'h02, 1'b0, 1'b0};
        tbl[9]  = '{4'hC, 2'd0, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[10] = '{4'h9, 2'd3, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[11] = '{4'h4, 2'd3, 8'h00, 8'hFE, 1'b0, 1'b0};
        tbl[12] = '{4'h5, 2'd3, 8'h0F, 8'h0E, 1'b0, 1'b0};
        tbl[13] = '{4'h6, 2'd3, 8'hF0, 8'hFE, 1'b0, 1'b0};
        tbl[14] = '{4'h7, 2'd3, 8'hFE, 8'h00, 1'b0, 1'b1};
        tbl[15] = '{4'h2, 2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[16] = '{4'h2, 2'd2, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[17] = '{4'h1, 2'd2, 8'h01, 8'h01, 1'b1, 1'b0};
        tbl[18] = '{4'hB, 2'd2, 8'hFE, 8'h00, 1'b1, 1'b1};
        tbl[19] = '{4'hC, 2'd1, 8'h01, 8'h02, 1'b1, 1'b0};
        tbl[20] = '{4'h9, 2'd1, 8'h0F, 8'h00, 1'b1, 1'b1};
        tbl[21] = '{4'hC, 2'd1, 8'h00, 8'h02, 1'b1, 1'b0};
        tbl[22] = '{4'h3, 2'd1, 8'h01, 8'h01, 1'b0, 1'b0};

        bus.inst       = '0;
        bus.inst_valid = 1'b0;
        bus.rd_sel     = '0;

        // Reset values while reset is held
        #2;
        for (int s = 0; s < 4; s++) begin
            bus.rd_sel = A'(s);
            #1 chk("reset_result", 64'(bus.result), 64'h0);
        end
        chk("reset_flags", {bus.inst_ready, bus.carry, bus.zero, bus.error}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_release_ready", 64'(bus.inst_ready), 64'h0);
        @(negedge clk);
        chk("first_edge_ready", 64'(bus.inst_ready), 64'h1);

        // Single-cycle opcode table, back-to-back
        for (int k = 0; k < NV; k++) begin
            bus.rd_sel = tbl[k].sel;
            send(tbl[k].code, tbl[k].sel, tbl[k].imm);
            chk($sformatf("vec%0d_result", k), 64'(bus.result), 64'(tbl[k].res));
            chk($sformatf("vec%0d_carry", k), 64'(bus.carry), 64'(tbl[k].c));
            chk($sformatf("vec%0d_zero", k), 64'(bus.zero), 64'(tbl[k].z));
        end

        // Combinational readback follows rd_sel with no clock
        bus.rd_sel = 2'd0;
        #1 chk("rdsel0", 64'(bus.result), 64'h02);
        bus.rd_sel = 2'd3;
        #1 chk("rdsel3", 64'(bus.result), 64'h00);
        bus.rd_sel = 2'd2;
        #1 chk("rdsel2", 64'(bus.result), 64'h00);
        @(negedge clk);

        // MUL 0x10*0x11 with a second instruction held valid during Busy
        send(4'h1, 2'd2, 8'h10);
        bus.inst       = {4'hA, 2'd2, 8'h11};
        bus.inst_valid = 1'b1;
        wait_ready("mul_ready");
        @(posedge clk);
        @(negedge clk);
        bus.inst   = {4'h1, 2'd1, 8'h55};
        bus.rd_sel = 2'd1;
        cnt = 0;
        while (!bus.inst_ready && cnt < 50) begin
            cnt++;
            if (bus.result !== 8'h01) begin
                nvec++;
                nerr++;
                $display("FAIL busy_hold: acc1 got %0h during Busy, expected 1", bus.result);
            end
            @(negedge clk);
        end
        chk("mul_busy_cycles", 64'(cnt), 64'd8);
        bus.rd_sel = 2'd2;
        #1 chk("mul_result", 64'(bus.result), 64'h10);
        chk("mul_carry", 64'(bus.carry), 64'h1);
        chk("mul_zero", 64'(bus.zero), 64'h0);
        @(posedge clk);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        bus.rd_sel = 2'd1;
        #1 chk("held_inst_after_busy", 64'(bus.result), 64'h55);
        chk("held_inst_zero", 64'(bus.zero), 64'h0);
        @(negedge clk);

        // Illegal opcode locks the bank in Error until reset
        send(4'hE, 2'd1, 8'h00);
        for (int s = 0; s < 4; s++) begin
            bus.rd_sel = A'(s);
            #1 chk("error_acc_clear", 64'(bus.result), 64'h0);
        end
        chk("error_flags", {bus.error, bus.inst_ready, bus.carry, bus.zero}, 4'b1000);
        bus.inst       = {4'h1, 2'd0, 8'h77};
        bus.inst_valid = 1'b1;
        bus.rd_sel     = 2'd0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("error_sticky", {bus.error, bus.inst_ready, bus.result}, {1'b1, 1'b0, 8'h00});
        end
        bus.inst_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("error_reset", {bus.error, bus.inst_ready}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("error_reset_release", 64'(bus.inst_ready), 64'h0);
        @(negedge clk);
        chk("error_reset_ready", {bus.error, bus.inst_ready}, 2'b01);

        // Reset three cycles into a MUL discards the partial product
        send(4'h1, 2'd1, 8'h0F);
        bus.inst       = {4'hA, 2'd1, 8'h0F};
        bus.inst_valid = 1'b1;
        wait_ready("mul2_ready");
        @(posedge clk);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        bus.rd_sel     = 2'd1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midmul_reset_result", 64'(bus.result), 64'h0);
        chk("midmul_reset_flags", {bus.inst_ready, bus.carry, bus.zero, bus.error}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            bus.rd_sel = A'(s);
            #1 chk("no_late_write", 64'(bus.result), 64'h0);
        end
        chk("post_midmul_state", {bus.inst_ready, bus.carry, bus.zero}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
